// File: rtl/regfile_wb_scheduler_pkg.sv
// Shared register-file types for the write-back scheduler and its result buffer.
// Holds the register address and word types, the buffered entry struct and a helper.
package regfile_wb_scheduler_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int WORD_W     = 32;
   localparam int NUM_REGS   = 1 << REG_ADDR_W;

   typedef logic [REG_ADDR_W-1:0] RegAddress;
   typedef logic [WORD_W-1:0]     Word;

   typedef struct packed {
      RegAddress addr;
      Word       data;
   } WbEntry;

   // Register 0 is hard-wired; writes and issues targeting it are ignored.
   function automatic logic is_x0(input RegAddress a);
      return (a == RegAddress'(0));
   endfunction

endpackage

// File: rtl/regfile_wb_scheduler_wb_fifo.sv
// Synchronous FIFO of pending long-latency write-backs with a registered count.
// The head is read straight from storage, so a pushed entry is visible only after its edge.
module wb_fifo
   import regfile_wb_scheduler_pkg::*;
#(
   parameter int DEPTH = 2
)(
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  WbEntry                   push_entry,
   input  logic                     pop,
   output WbEntry                   head,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   WbEntry             mem_q [DEPTH];
   WbEntry             mem_d [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               do_push_s;
   logic               do_pop_s;

   assign full  = (count_q == CNT_W'(DEPTH));
   assign empty = (count_q == CNT_W'(0));
   assign count = count_q;
   assign head  = mem_q[rd_ptr_q];

   // Next-state for storage, pointers and occupancy.
   always_comb begin
      mem_d     = mem_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      do_push_s = push && !full;
      do_pop_s  = pop && !empty;
      if (do_push_s) begin
         mem_d[wr_ptr_q] = push_entry;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (do_pop_s) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({do_push_s, do_pop_s})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // Pointer and count registers; reset drops every buffered entry.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= PTR_W'(0);
         rd_ptr_q <= PTR_W'(0);
         count_q  <= CNT_W'(0);
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage needs no reset: it is only observed through a non-zero count.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Shares the single register-file write port between pipeline write-back and a
// long-latency unit, and keeps the scoreboard that stalls decode on outstanding results.
module regfile_wb_scheduler
   import regfile_wb_scheduler_pkg::*;
#(
   parameter int QUEUE_DEPTH  = 2,
   parameter int STARVE_LIMIT = 4
)(
   input  logic                clk,
   input  logic                reset,
   input  logic                pipe_valid,
   input  RegAddress           pipe_addr,
   input  Word                 pipe_data,
   input  logic                lu_valid,
   output logic                lu_ready,
   input  RegAddress           lu_addr,
   input  Word                 lu_data,
   input  logic                issue_valid,
   input  RegAddress           issue_addr,
   input  RegAddress           rs1_addr,
   input  RegAddress           rs2_addr,
   input  RegAddress           rd_addr,
   output logic                hazard_stall,
   output logic                wb_hold,
   output logic                rf_write_enable,
   output RegAddress           rf_addr_write,
   output Word                 rf_in,
   output logic [NUM_REGS-1:0] busy
);

   localparam int AGE_W = $clog2(STARVE_LIMIT + 1);
   localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;

   logic [NUM_REGS-1:0] busy_q, busy_d;
   logic [AGE_W-1:0]    age_q, age_d;
   WbEntry              fifo_head_s;
   WbEntry              fifo_push_entry_s;
   logic                fifo_full_s;
   logic                fifo_empty_s;
   logic [CNT_W-1:0]    fifo_count_s;
   logic                fifo_push_s;
   logic                fifo_pop_s;
   logic                pipe_own_s;

   wb_fifo #(.DEPTH(QUEUE_DEPTH)) u_wb_fifo (
      .clk        (clk),
      .reset      (reset),
      .push       (fifo_push_s),
      .push_entry (fifo_push_entry_s),
      .pop        (fifo_pop_s),
      .head       (fifo_head_s),
      .full       (fifo_full_s),
      .empty      (fifo_empty_s),
      .count      (fifo_count_s)
   );

   assign lu_ready          = !fifo_full_s;
   assign fifo_push_entry_s = '{addr: lu_addr, data: lu_data};
   assign busy              = busy_q;
   assign wb_hold           = fifo_full_s || (age_q >= AGE_W'(STARVE_LIMIT));
   assign hazard_stall      = busy_q[rs1_addr] | busy_q[rs2_addr] | busy_q[rd_addr];

   // Port arbitration: a real pipeline write always wins, else the buffer head drains.
   always_comb begin
      pipe_own_s      = pipe_valid && !is_x0(pipe_addr);
      fifo_push_s     = lu_valid && lu_ready && !is_x0(lu_addr);
      fifo_pop_s      = 1'b0;
      rf_write_enable = 1'b0;
      rf_addr_write   = RegAddress'(0);
      rf_in           = Word'(0);
      if (pipe_own_s) begin
         rf_write_enable = 1'b1;
         rf_addr_write   = pipe_addr;
         rf_in           = pipe_data;
      end else if (!fifo_empty_s) begin
         fifo_pop_s      = 1'b1;
         rf_write_enable = 1'b1;
         rf_addr_write   = fifo_head_s.addr;
         rf_in           = fifo_head_s.data;
      end else begin
         fifo_pop_s = 1'b0;
      end
   end

   // Scoreboard and head-age next state; a same-cycle issue overrides the commit clear.
   always_comb begin
      busy_d = busy_q;
      if (fifo_pop_s) begin
         busy_d[fifo_head_s.addr] = 1'b0;
      end else begin
         busy_d = busy_q;
      end
      if (issue_valid && !is_x0(issue_addr)) begin
         busy_d[issue_addr] = 1'b1;
      end else begin
         busy_d[0] = 1'b0;
      end
      busy_d[0] = 1'b0;

      if (fifo_empty_s || fifo_pop_s) begin
         age_d = AGE_W'(0);
      end else if (age_q < AGE_W'(STARVE_LIMIT)) begin
         age_d = age_q + AGE_W'(1);
      end else begin
         age_d = age_q;
      end
   end

   // Scoreboard and age registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         busy_q <= '0;
         age_q  <= AGE_W'(0);
      end else begin
         busy_q <= busy_d;
         age_q  <= age_d;
      end
   end

endmodule
